// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write-side controller:
// FSM state encoding, lcd_o bit positions, the power-on init ROM and
// the opcodes that need the long post-command wait.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_POWERUP,
      ST_INIT_ISSUE,
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_WAIT
   } lcd_state_e;

   // Bit positions inside the 32-bit LCD I/O word
   localparam int LCD_ON_BIT = 31;
   localparam int LCD_EN_BIT = 10;
   localparam int LCD_RS_BIT = 9;
   localparam int LCD_RW_BIT = 8;

   // Power-on init: 8-bit/2-line, display on, clear, entry mode increment
   localparam int INIT_LEN   = 4;
   localparam int INIT_IDX_W = $clog2(INIT_LEN) + 1;
   localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h0C, 8'h01, 8'h06};

   // Instructions that take the long execution time
   localparam logic [7:0] OP_CLEAR    = 8'h01;
   localparam logic [7:0] OP_HOME     = 8'h02;
   localparam logic [7:0] OP_HOME_ALT = 8'h03;

   // True for clear/home instructions, which need T_CLEAR instead of T_EXEC
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return !rs && ((data == OP_CLEAR) || (data == OP_HOME) || (data == OP_HOME_ALT));
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter shared by every controller state. A state that
// must last N cycles loads N-1 on entry; done is high while the count is 0.
module lcd_delay_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             done
);

   logic [WIDTH-1:0] count_q;

   // Reload on request, otherwise count down and park at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_value;
      end else if (count_q != '0) begin
         count_q <= count_q - WIDTH'(1);
      end
   end

   assign done = (count_q == '0);

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 write-side controller. Accepts instruction/character bytes over
// valid/ready and generates the full LCD write cycle: RS/data setup, EN
// pulse, hold and the post-command execution wait. lcd_o uses the
// processor's LCD I/O word packing (ON, EN, RS, RW, DATA).
// Optional feature: define LCD_INIT_EN to add a power-on delay followed by
// an automatic init sequence before the first item is accepted.
module lcd_hd44780_ctrl
   import lcd_pkg::*;
#(
   parameter int T_SETUP   = 4,
   parameter int T_EN_HIGH = 25,
   parameter int T_HOLD    = 4,
   parameter int T_EXEC    = 2500,
   parameter int T_CLEAR   = 82000,
   parameter int T_POWERUP = 2000000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_rs_i,
   input  logic [7:0]  cmd_data_i,
   output logic        busy_o,
   output logic [31:0] lcd_o
);

   localparam int MAX_T = max_int(max_int(max_int(T_SETUP, T_EN_HIGH), max_int(T_HOLD, T_EXEC)),
                                  max_int(T_CLEAR, T_POWERUP));
   localparam int CNT_W = $clog2(MAX_T) + 1;

   localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0] EN_LOAD    = CNT_W'(T_EN_HIGH - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(T_HOLD - 1);
   localparam logic [CNT_W-1:0] EXEC_LOAD  = CNT_W'(T_EXEC - 1);
   localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(T_CLEAR - 1);

   lcd_state_e       state_q;
   logic             ready_q;
   logic             on_q;
   logic             en_q;
   logic             rs_q;
   logic [7:0]       data_q;
   logic             accept;
   logic             timer_load;
   logic [CNT_W-1:0] timer_value;
   logic             timer_done;
   logic [31:0]      lcd_word;

`ifdef LCD_INIT_EN
   // The arming cycle and the INIT_ISSUE cycle are part of the power-up
   // window, so the first init item is issued T_POWERUP edges after reset.
   localparam logic [CNT_W-1:0] POWERUP_LOAD = CNT_W'((T_POWERUP > 3) ? (T_POWERUP - 3) : 0);

   logic                  powerup_armed_q;
   logic [INIT_IDX_W-1:0] init_idx_q;
   logic                  init_pending;

   assign init_pending = (init_idx_q < INIT_IDX_W'(INIT_LEN));
`endif

   assign accept = ready_q && cmd_valid_i;

   lcd_delay_timer #(
      .WIDTH (CNT_W)
   ) u_timer (
      .clk        (clk_i),
      .rst_n      (rst_ni),
      .load       (timer_load),
      .load_value (timer_value),
      .done       (timer_done)
   );

   // Decide when the shared timer is reloaded and with which duration
   always_comb begin
      timer_load  = 1'b0;
      timer_value = '0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               timer_load  = 1'b1;
               timer_value = SETUP_LOAD;
            end
         end
         ST_SETUP: begin
            if (timer_done) begin
               timer_load  = 1'b1;
               timer_value = EN_LOAD;
            end
         end
         ST_PULSE: begin
            if (timer_done) begin
               timer_load  = 1'b1;
               timer_value = HOLD_LOAD;
            end
         end
         ST_HOLD: begin
            if (timer_done) begin
               timer_load  = 1'b1;
               timer_value = is_long_cmd(rs_q, data_q) ? CLEAR_LOAD : EXEC_LOAD;
            end
         end
`ifdef LCD_INIT_EN
         ST_WAIT: begin
            if (timer_done && init_pending) begin
               timer_load  = 1'b1;
               timer_value = SETUP_LOAD;
            end
         end
         ST_POWERUP: begin
            if (!powerup_armed_q) begin
               timer_load  = 1'b1;
               timer_value = POWERUP_LOAD;
            end
         end
         ST_INIT_ISSUE: begin
            timer_load  = 1'b1;
            timer_value = SETUP_LOAD;
         end
`endif
         default: begin
            timer_load  = 1'b0;
         end
      endcase
   end

   // Write-cycle sequencer; all LCD bus fields and ready are registered here
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
`ifdef LCD_INIT_EN
         state_q         <= ST_POWERUP;
         powerup_armed_q <= 1'b0;
         init_idx_q      <= '0;
`else
         state_q         <= ST_IDLE;
`endif
         ready_q <= 1'b0;
         on_q    <= 1'b0;
         en_q    <= 1'b0;
         rs_q    <= 1'b0;
         data_q  <= '0;
      end else begin
         on_q <= 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  rs_q    <= cmd_rs_i;
                  data_q  <= cmd_data_i;
                  ready_q <= 1'b0;
                  state_q <= ST_SETUP;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            ST_SETUP: begin
               if (timer_done) begin
                  en_q    <= 1'b1;
                  state_q <= ST_PULSE;
               end
            end
            ST_PULSE: begin
               if (timer_done) begin
                  en_q    <= 1'b0;
                  state_q <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (timer_done) begin
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (timer_done) begin
`ifdef LCD_INIT_EN
                  if (init_pending) begin
                     rs_q       <= 1'b0;
                     data_q     <= INIT_ROM[init_idx_q[INIT_IDX_W-2:0]];
                     init_idx_q <= init_idx_q + INIT_IDX_W'(1);
                     state_q    <= ST_SETUP;
                  end else begin
                     ready_q <= 1'b1;
                     state_q <= ST_IDLE;
                  end
`else
                  ready_q <= 1'b1;
                  state_q <= ST_IDLE;
`endif
               end
            end
`ifdef LCD_INIT_EN
            ST_POWERUP: begin
               if (!powerup_armed_q) begin
                  powerup_armed_q <= 1'b1;
               end else if (timer_done) begin
                  state_q <= ST_INIT_ISSUE;
               end
            end
            ST_INIT_ISSUE: begin
               rs_q       <= 1'b0;
               data_q     <= INIT_ROM[init_idx_q[INIT_IDX_W-2:0]];
               init_idx_q <= init_idx_q + INIT_IDX_W'(1);
               state_q    <= ST_SETUP;
            end
`endif
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Pack the registered bus fields into the LCD I/O word
   always_comb begin
      lcd_word             = '0;
      lcd_word[LCD_ON_BIT] = on_q;
      lcd_word[LCD_EN_BIT] = en_q;
      lcd_word[LCD_RS_BIT] = rs_q;
      lcd_word[LCD_RW_BIT] = 1'b0;
      lcd_word[7:0]        = data_q;
   end

   assign lcd_o       = lcd_word;
   assign cmd_ready_o = ready_q;
   assign busy_o      = ~ready_q;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Bench for lcd_hd44780_ctrl: a timeline model (each accepted item known by
// its accept edge, from which EN and ready windows follow arithmetically)
// is compared against the DUT on every falling edge, alongside directed
// checks with hand-computed latencies and randomized valid/rs/data traffic.
// Honours LCD_INIT_EN when defined for the whole build.
module tb_lcd_hd44780_ctrl;

   localparam int TS = 2;
   localparam int TE = 3;
   localparam int TH = 1;
   localparam int TX = 5;
   localparam int TC = 20;
   localparam int TP = 10;

`ifdef LCD_INIT_EN
   localparam bit INIT_MODE = 1'b1;
`else
   localparam bit INIT_MODE = 1'b0;
`endif

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_rs    = 1'b0;
   logic [7:0]  cmd_data  = 8'h00;
   logic        cmd_ready;
   logic        busy;
   logic [31:0] lcd;

   int tests_run    = 0;
   int tests_failed = 0;

   lcd_hd44780_ctrl #(
      .T_SETUP   (TS),
      .T_EN_HIGH (TE),
      .T_HOLD    (TH),
      .T_EXEC    (TX),
      .T_CLEAR   (TC),
      .T_POWERUP (TP)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_rs_i    (cmd_rs),
      .cmd_data_i  (cmd_data),
      .busy_o      (busy),
      .lcd_o       (lcd)
   );

   always #5 clk = ~clk;

   // ---------------- reference timeline model ----------------
   int         m_n      = 0;
   bit         m_ready  = 1'b0;
   bit         m_active = 1'b0;
   int         m_k      = 0;
   int         m_done   = 0;
   bit         m_rs     = 1'b0;
   logic [7:0] m_data   = 8'h00;
   int         m_init_pos = 0;
   logic [7:0] init_seq [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

   function automatic int wait_len(input bit rs, input logic [7:0] d);
      if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return TC;
      return TX;
   endfunction

   function automatic void start_item(input int at, input bit rs, input logic [7:0] d);
      m_active = 1'b1;
      m_k      = at;
      m_rs     = rs;
      m_data   = d;
      m_done   = at + TS + TE + TH + wait_len(rs, d);
      m_ready  = 1'b0;
   endfunction

   function automatic logic [31:0] exp_lcd();
      logic [31:0] w;
      bit en;
      w  = 32'h0;
      en = m_active && (m_n >= m_k + TS) && (m_n < m_k + TS + TE);
      if (m_n >= 1) w = w | 32'h8000_0000;
      if (en)       w = w | 32'h0000_0400;
      if (m_rs)     w = w | 32'h0000_0200;
      w = w | {24'h0, m_data};
      return w;
   endfunction

   // Advance the model at each rising edge; reset clears it at once
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_n = 0; m_ready = 1'b0; m_active = 1'b0; m_k = 0; m_done = 0;
            m_rs = 1'b0; m_data = 8'h00; m_init_pos = 0;
         end else begin
            m_n++;
            if (m_ready && cmd_valid) begin
               start_item(m_n, cmd_rs, cmd_data);
            end else if (m_active && m_n == m_done) begin
               m_active = 1'b0;
               if (INIT_MODE && m_init_pos < 4) begin
                  start_item(m_n, 1'b0, init_seq[m_init_pos]);
                  m_init_pos++;
               end else begin
                  m_ready = 1'b1;
               end
            end else if (!m_active && !m_ready) begin
               if (!INIT_MODE) begin
                  m_ready = 1'b1;
               end else if (m_n == TP && m_init_pos == 0) begin
                  start_item(m_n, 1'b0, init_seq[0]);
                  m_init_pos = 1;
               end
            end
         end
      end
   end

   // ---------------- checking helpers ----------------
   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic note_timeout(input string name);
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s: timed out waiting, expected event within bound", name);
   endtask

   // Compare DUT outputs against the model on every falling edge
   initial begin
      forever begin
         @(negedge clk);
         check_output("model_lcd", lcd, exp_lcd());
         check_output("model_ready", {31'b0, cmd_ready}, {31'b0, m_ready});
         check_output("model_busy", {31'b0, busy}, {31'b0, !m_ready});
      end
   end

   // ---------------- stimulus tasks ----------------
   task automatic wait_ready(input string name);
      bit got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         if (cmd_ready) got = 1'b1;
         else @(negedge clk);
      end
      if (!got) note_timeout(name);
   endtask

   task automatic init_sequence_check(input string name);
      logic [7:0] pulses[$];
      bit         prev_en = 1'b0;
      int         rdy     = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (lcd[10] && !prev_en) pulses.push_back(lcd[7:0]);
         prev_en = lcd[10];
         if (cmd_ready) begin
            rdy = m_n;
            break;
         end
      end
      if (rdy < 0) note_timeout({name, "_ready"});
      check_output({name, "_pulse_count"}, 32'(pulses.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check_output({name, "_pulse_data"}, (i < pulses.size()) ? {24'h0, pulses[i]} : 32'hFFFF_FFFF,
                      {24'h0, init_seq[i]});
      end
      check_output({name, "_ready_edge"}, 32'(rdy), 32'd69);
   endtask

   task automatic apply_reset(input string name);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_output({name, "_lcd_in_reset"}, lcd, 32'h0000_0000);
      check_output({name, "_busy_in_reset"}, {31'b0, busy}, 32'd1);
      rst_n = 1'b1;
      if (INIT_MODE) begin
         init_sequence_check({name, "_init"});
      end else begin
         @(negedge clk);
         check_output({name, "_lcd_after_release"}, lcd, 32'h8000_0000);
         check_output({name, "_ready_after_release"}, {31'b0, cmd_ready}, 32'd1);
      end
   endtask

   task automatic apply_stimulus(input bit rs, input logic [7:0] d, input int exp_lat, input string name);
      int acc;
      int rise = -1;
      int fall = -1;
      int rdy  = -1;
      cmd_valid = 1'b1;
      cmd_rs    = rs;
      cmd_data  = d;
      wait_ready({name, "_idle"});
      @(negedge clk);
      acc       = m_n;
      cmd_valid = 1'b0;
      check_output({name, "_lcd_on_accept"}, lcd, 32'h8000_0000 | (32'(rs) << 9) | {24'h0, d});
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (lcd[10] && rise < 0) rise = m_n;
         if (!lcd[10] && rise >= 0 && fall < 0) fall = m_n;
         if (cmd_ready) begin
            rdy = m_n;
            break;
         end
      end
      if (rdy < 0) note_timeout({name, "_ready"});
      check_output({name, "_en_rise"}, 32'(rise - acc), 32'd2);
      check_output({name, "_en_fall"}, 32'(fall - acc), 32'd5);
      check_output({name, "_ready_latency"}, 32'(rdy - acc), 32'(exp_lat));
   endtask

   // Valid stays high with new data every cycle; only the first item may show
   task automatic hold_valid_test();
      bit seen = 1'b0;
      cmd_valid = 1'b1;
      cmd_rs    = 1'b1;
      cmd_data  = 8'h55;
      wait_ready("hold_idle");
      @(negedge clk);
      check_output("hold_first_accept", lcd, 32'h8000_0255);
      for (int i = 0; i < 200 && !seen; i++) begin
         if (cmd_ready) begin
            seen = 1'b1;
         end else begin
            cmd_rs   = 1'($urandom);
            cmd_data = 8'($urandom);
            @(negedge clk);
         end
      end
      if (!seen) note_timeout("hold_ready");
      check_output("hold_data_unchanged", lcd, 32'h8000_0255);
      cmd_rs   = 1'b0;
      cmd_data = 8'h66;
      @(negedge clk);
      cmd_valid = 1'b0;
      check_output("hold_next_accept", lcd, 32'h8000_0066);
      check_output("hold_busy_again", {31'b0, cmd_ready}, 32'd0);
      @(negedge clk);
      wait_ready("hold_drain");
   endtask

   // Reset asserted mid-PULSE must drop EN and clear the word immediately
   task automatic reset_in_pulse();
      bit en_seen = 1'b0;
      cmd_valid = 1'b1;
      cmd_rs    = 1'b1;
      cmd_data  = 8'h5A;
      wait_ready("rstp_idle");
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 20 && !en_seen; i++) begin
         if (lcd[10]) en_seen = 1'b1;
         else @(negedge clk);
      end
      if (!en_seen) note_timeout("rstp_en");
      #2;
      rst_n = 1'b0;
      #1;
      check_output("rstp_async_lcd", lcd, 32'h0000_0000);
      check_output("rstp_async_busy", {31'b0, busy}, 32'd1);
      @(negedge clk);
      apply_reset("rstp");
   endtask

   task automatic random_traffic(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         cmd_valid = ($urandom % 3) != 0;
         cmd_rs    = 1'($urandom);
         cmd_data  = (($urandom % 4) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      @(negedge clk);
      wait_ready("random_drain");
   endtask

   // ---------------- main sequence ----------------
   initial begin
      $display("[TB] lcd_hd44780_ctrl bench start (init sequence %0d)", INIT_MODE);
      apply_reset("reset");
      apply_stimulus(1'b1, 8'h41, 11, "char_41");
      apply_stimulus(1'b0, 8'h01, 26, "clear");
      apply_stimulus(1'b1, 8'h01, 11, "data_01");
      apply_stimulus(1'b0, 8'h02, 26, "home");
      apply_stimulus(1'b0, 8'h03, 26, "home_alt");
      apply_stimulus(1'b0, 8'h04, 11, "cmd_04");
      hold_valid_test();
      reset_in_pulse();
      random_traffic(800);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Absolute guard so the run always ends
   initial begin
      #200000;
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL global_timeout: simulation did not finish, expected end before 200000");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
